// File: rtl/raizing_frac_cen.sv
// Fractional clock-enable generator: NCH independent channels, each pulsing CEN at CLK*NUM/DEN.
// Optional half-period CENB outputs are built only when RAIZING_CEN_B_EN is defined.
module raizing_frac_cen #(
    parameter int NCH = 4,
    parameter int NW  = 10,
    parameter int DW  = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NCH-1:0]    CFG_LD,
    input  logic [NCH*NW-1:0] NUM_IN,
    input  logic [NCH*DW-1:0] DEN_IN,
    input  logic [NCH-1:0]    HOLD,
    output logic [NCH-1:0]    CEN,
    output logic [NCH-1:0]    CENB,
    output logic [NCH-1:0]    ERR
);

    localparam int AW = ((NW > DW) ? NW : DW) + 1;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [NW-1:0] num_in;
            logic [DW-1:0] den_in;
            logic [NW-1:0] num_q, num_d;
            logic [DW-1:0] den_q, den_d;
            logic [AW-1:0] acc_q, acc_d;
            logic [AW-1:0] sum;
            logic [AW-1:0] den_ext;
            logic          cen_q, cen_d;
            logic          err_q, err_d;
            logic          run;

            assign num_in = NUM_IN[gi*NW +: NW];
            assign den_in = DEN_IN[gi*DW +: DW];

            // acc < den and num <= den whenever running, so the sum never overflows AW bits.
            assign sum     = acc_q + AW'(num_q);
            assign den_ext = AW'(den_q);
            // A zero numerator (including the post-reset state with den=0) must never pulse.
            assign run     = !CFG_LD[gi] && !HOLD[gi] && !err_q && (num_q != '0);

            always_comb begin
                num_d = num_q;
                den_d = den_q;
                acc_d = acc_q;
                err_d = err_q;
                cen_d = 1'b0;
                if (CFG_LD[gi]) begin
                    num_d = num_in;
                    den_d = den_in;
                    acc_d = '0;
                    err_d = (den_in == '0) || (AW'(num_in) > AW'(den_in));
                end else if (run) begin
                    if (sum >= den_ext) begin
                        acc_d = sum - den_ext;
                        cen_d = 1'b1;
                    end else begin
                        acc_d = sum;
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    num_q <= '0;
                    den_q <= '0;
                    acc_q <= '0;
                    err_q <= 1'b0;
                    cen_q <= 1'b0;
                end else begin
                    num_q <= num_d;
                    den_q <= den_d;
                    acc_q <= acc_d;
                    err_q <= err_d;
                    cen_q <= cen_d;
                end
            end

            assign CEN[gi] = cen_q;
            assign ERR[gi] = err_q;

`ifdef RAIZING_CEN_B_EN
            logic [AW-1:0] half;
            logic          cenb_q, cenb_d;

            assign half = AW'(den_q >> 1);

            // Fires when the accumulator crosses the half-way mark without wrapping this cycle.
            always_comb begin
                cenb_d = run && (acc_q < half) && (sum >= half) && (sum < den_ext);
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    cenb_q <= 1'b0;
                end else begin
                    cenb_q <= cenb_d;
                end
            end

            assign CENB[gi] = cenb_q;
`else
            assign CENB[gi] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_raizing_frac_cen.sv
// Directed self-checking bench for raizing_frac_cen; CENB expectations follow RAIZING_CEN_B_EN.
module tb_raizing_frac_cen;

    localparam int NCH = 4;
    localparam int NW  = 10;
    localparam int DW  = 10;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [NCH-1:0]    CFG_LD;
    logic [NCH*NW-1:0] NUM_IN;
    logic [NCH*DW-1:0] DEN_IN;
    logic [NCH-1:0]    HOLD;
    logic [NCH-1:0]    CEN;
    logic [NCH-1:0]    CENB;
    logic [NCH-1:0]    ERR;

    int n_checks = 0;
    int n_pass   = 0;

    raizing_frac_cen #(.NCH(NCH), .NW(NW), .DW(DW)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .CFG_LD (CFG_LD),
        .NUM_IN (NUM_IN),
        .DEN_IN (DEN_IN),
        .HOLD   (HOLD),
        .CEN    (CEN),
        .CENB   (CENB),
        .ERR    (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input int ch, input int n, input int d);
        logic [31:0] nv;
        logic [31:0] dv;
        nv = n;
        dv = d;
        NUM_IN[ch*NW +: NW] = nv[NW-1:0];
        DEN_IN[ch*DW +: DW] = dv[DW-1:0];
        CFG_LD[ch] = 1'b1;
        step();
        CFG_LD[ch] = 1'b0;
        $display("tb: load ch%0d num=%0d den=%0d", ch, n, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, last, first, bad, gap, seen;
        bit cenb_en;
`ifdef RAIZING_CEN_B_EN
        cenb_en = 1'b1;
`else
        cenb_en = 1'b0;
`endif
        RESET  = 1'b1;
        CFG_LD = '0;
        NUM_IN = '0;
        DEN_IN = '0;
        HOLD   = '0;
        repeat (3) step();
        check("rst_cen", 32'(CEN), 0);
        check("rst_cenb", 32'(CENB), 0);
        check("rst_err", 32'(ERR), 0);
        RESET = 1'b0;
        repeat (4) step();
        check("idle_cen", 32'(CEN), 0);

        // 1: ch0 1/4
        load(0, 1, 4);
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("t1_cen_e%0d", k), 32'(CEN[0]), 32'(k % 4 == 0));
            check($sformatf("t1_cenb_e%0d", k), 32'(CENB[0]), 32'(cenb_en && (k % 4 == 2)));
        end

        // 2: ch1 9/64 over 6400 cycles
        load(1, 9, 64);
        cnt = 0; last = 0; first = 0; bad = 0;
        for (int k = 1; k <= 6400; k++) begin
            step();
            if (CEN[1]) begin
                if (first == 0) first = k;
                if (last != 0 && (k - last) != 7 && (k - last) != 8) bad++;
                last = k;
                cnt++;
            end
        end
        check("t2_count", cnt, 900);
        check("t2_first", first, 8);
        check("t2_badgap", bad, 0);
        $display("tb: ch1 pulses=%0d", cnt);

        // 3: ch2 5/5 with a 3-cycle hold
        load(2, 5, 5);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("t3_run_e%0d", k), 32'(CEN[2]), 1);
        end
        HOLD[2] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("t3_hold_e%0d", k), 32'(CEN[2]), 0);
        end
        HOLD[2] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("t3_resume_e%0d", k), 32'(CEN[2]), 1);
        end

        // 4: ch3 bad config then valid reload
        load(3, 7, 3);
        check("t4_err_set", 32'(ERR[3]), 1);
        seen = 0;
        repeat (5) begin
            step();
            seen |= int'(CEN[3]);
        end
        check("t4_err_nocen", seen, 0);
        load(3, 1, 2);
        check("t4_err_clr", 32'(ERR[3]), 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("t4_cen_e%0d", k), 32'(CEN[3]), 32'(k % 2 == 0));
        end

        // 5: ch0 1/12, hold at acc=5, then load together with hold
        load(0, 1, 12);
        repeat (5) step();
        HOLD[0] = 1'b1;
        seen = 0;
        repeat (10) begin
            step();
            seen |= int'(CEN[0]);
        end
        check("t5_hold_nocen", seen, 0);
        HOLD[0] = 1'b0;
        gap = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (CEN[0]) begin
                gap = k;
                break;
            end
        end
        check("t5_resume_gap", gap, 7);
        repeat (3) step();
        HOLD[0] = 1'b1;
        load(0, 1, 12);
        repeat (2) step();
        HOLD[0] = 1'b0;
        gap = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (CEN[0]) begin
                gap = k;
                break;
            end
        end
        check("t5_load_hold_gap", gap, 12);

        // 6: reset mid-run
        load(3, 3, 0);
        check("t6_err_pre", 32'(ERR[3]), 1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("t6_cen", 32'(CEN), 0);
        check("t6_cenb", 32'(CENB), 0);
        check("t6_err", 32'(ERR), 0);
        seen = 0;
        repeat (20) begin
            step();
            seen |= int'(CEN) | int'(CENB) | int'(ERR);
        end
        check("t6_quiet", seen, 0);
        load(2, 5, 5);
        step();
        check("t6_reload", 32'(CEN[2]), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
